dvv_bcast_fifo: RTL and testbench

- Synthesizable hardware analysis broadcast port. One producer writes transactions; every enabled subscriber independently receives each transaction in order.
- Single shared storage array. One write pointer, one read pointer per subscriber.
- A slot is reclaimed only after every enabled subscriber has consumed it.
- Used in DUT-side monitors and trace taps that fan one transaction stream out to several checkers or loggers.

---
 rtl/dvv_bcast_pkg.sv | 18 +
 rtl/dvv_bcast_rd_ptr.sv | 56 +++++
 rtl/dvv_bcast_fifo.sv | 94 +++++++++
 tb/tb_dvv_bcast_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvv_bcast_pkg.sv
// Shared definitions for the dvv_bcast_fifo broadcast port.
// The optional statistics build is enabled by defining DVV_BCAST_STAT_EN.
package dvv_bcast_pkg;

    localparam int MAX_SUBS = 16;
    localparam int MAX_PW   = 17;

    // Pointer width carries one extra wrap bit so that full and empty differ.
    function automatic int PTR_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [31:0]                stall_cnt;
        logic [MAX_SUBS*MAX_PW-1:0] max_level;
    } dvv_bcast_stat_t;

endpackage

// File: rtl/dvv_bcast_rd_ptr.sv
// Per-subscriber read pointer: occupancy, valid, full contribution, enable tracking.
// With DVV_BCAST_STAT_EN defined it also keeps the subscriber's high-water mark.
module dvv_bcast_rd_ptr
    import dvv_bcast_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = PTR_W(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          en,
    input  logic          ready,
    input  logic [PW-1:0] wp,
    input  logic [PW-1:0] wp_next,
    output logic [PW-1:0] rp,
    output logic [PW-1:0] lvl,
    output logic          valid,
    output logic          full
`ifdef DVV_BCAST_STAT_EN
    ,
    output logic [PW-1:0] max_level
`endif
);

    assign lvl   = wp - rp;
    assign valid = en && (lvl != '0);
    assign full  = en && (lvl == PW'(DEPTH));

    // A disabled port shadows the next write pointer, so it never blocks the
    // producer and comes back empty when re-enabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rp <= '0;
        end else if (flush) begin
            rp <= '0;
        end else if (!en) begin
            rp <= wp_next;
        end else if (valid && ready) begin
            rp <= rp + PW'(1);
        end
    end

`ifdef DVV_BCAST_STAT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            max_level <= '0;
        end else if (flush) begin
            max_level <= '0;
        end else if (en && (lvl > max_level)) begin
            max_level <= lvl;
        end
    end
`endif

endmodule

// File: rtl/dvv_bcast_fifo.sv
// Broadcast FIFO: one producer, NUM_SUBS independent in-order subscribers over shared storage.
// Define DVV_BCAST_STAT_EN to add stall_cnt and per-subscriber max_level outputs.
module dvv_bcast_fifo
    import dvv_bcast_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int NUM_SUBS = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           flush,
    input  logic [NUM_SUBS-1:0]            sub_en,
    input  logic                           wr_valid,
    input  logic [WIDTH-1:0]               wr_data,
    output logic                           wr_ready,
    output logic [NUM_SUBS-1:0]            rd_valid,
    output logic [NUM_SUBS*WIDTH-1:0]      rd_data,
    input  logic [NUM_SUBS-1:0]            rd_ready,
    output logic [NUM_SUBS*PTR_W(DEPTH)-1:0] level
`ifdef DVV_BCAST_STAT_EN
    ,
    output logic [31:0]                    stall_cnt,
    output logic [NUM_SUBS*PTR_W(DEPTH)-1:0] max_level
`endif
);

    localparam int PW = PTR_W(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PW-1:0]       wp;
    logic [PW-1:0]       wp_next;
    logic [PW-1:0]       rp [NUM_SUBS];
    logic [NUM_SUBS-1:0] full_vec;
    logic                accept;

    // Full is judged on registered pointers only; a same-cycle pop does not free a slot.
    assign wr_ready = ~|full_vec;
    assign accept   = wr_valid && wr_ready && !flush;
    assign wp_next  = flush ? '0 : wp + PW'(accept);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp <= '0;
        end else begin
            wp <= wp_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wp[AW-1:0]] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_SUBS; g++) begin : g_sub
        dvv_bcast_rd_ptr #(
            .DEPTH (DEPTH),
            .PW    (PW)
        ) u_rd_ptr (
            .clk       (clk),
            .resetn    (resetn),
            .flush     (flush),
            .en        (sub_en[g]),
            .ready     (rd_ready[g]),
            .wp        (wp),
            .wp_next   (wp_next),
            .rp        (rp[g]),
            .lvl       (level[g*PW +: PW]),
            .valid     (rd_valid[g]),
            .full      (full_vec[g])
`ifdef DVV_BCAST_STAT_EN
            ,
            .max_level (max_level[g*PW +: PW])
`endif
        );

        assign rd_data[g*WIDTH +: WIDTH] = mem[rp[g][AW-1:0]];
    end

`ifdef DVV_BCAST_STAT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (wr_valid && !wr_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dvv_bcast_fifo.sv
// Self-checking bench for dvv_bcast_fifo: directed scenarios plus randomized traffic
// compared each cycle against per-subscriber queues. Honours DVV_BCAST_STAT_EN.
module tb_dvv_bcast_fifo;
    import dvv_bcast_pkg::*;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 8;
    localparam int NUM_SUBS = 4;
    localparam int PW       = PTR_W(DEPTH);

    logic                       clk;
    logic                       resetn;
    logic                       flush;
    logic [NUM_SUBS-1:0]        sub_en;
    logic                       wr_valid;
    logic [WIDTH-1:0]           wr_data;
    logic                       wr_ready;
    logic [NUM_SUBS-1:0]        rd_valid;
    logic [NUM_SUBS*WIDTH-1:0]  rd_data;
    logic [NUM_SUBS-1:0]        rd_ready;
    logic [NUM_SUBS*PW-1:0]     level;
`ifdef DVV_BCAST_STAT_EN
    logic [31:0]                stall_cnt;
    logic [NUM_SUBS*PW-1:0]     max_level;
`endif

    dvv_bcast_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NUM_SUBS (NUM_SUBS)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .sub_en    (sub_en),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .level     (level)
`ifdef DVV_BCAST_STAT_EN
        ,
        .stall_cnt (stall_cnt),
        .max_level (max_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each subscriber sees the plain queue of items it still owes.
    typedef logic [WIDTH-1:0] dq_t [$];
    dq_t         mq [NUM_SUBS];
    logic [31:0] m_stall;
    int          m_max [NUM_SUBS];

    int errors = 0;
    int checks = 0;
    int got [NUM_SUBS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        for (int i = 0; i < NUM_SUBS; i++)
            if (sub_en[i] && mq[i].size() == DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_SUBS; i++) begin
            mq[i].delete();
            m_max[i] = 0;
        end
        m_stall = '0;
    endtask

    task automatic model_update();
        bit rdy;
        if (!resetn) begin
            model_clear();
            return;
        end
        rdy = m_ready();
        if (flush) begin
            model_clear();
            return;
        end
        if (wr_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        for (int i = 0; i < NUM_SUBS; i++) begin
            if (sub_en[i] && mq[i].size() > m_max[i]) m_max[i] = mq[i].size();
            if (!sub_en[i]) mq[i].delete();
            else if (rd_ready[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        end
        if (wr_valid && rdy)
            for (int i = 0; i < NUM_SUBS; i++)
                if (sub_en[i]) mq[i].push_back(wr_data);
    endtask

    task automatic check_all();
        bit ev;
        chk("wr_ready", wr_ready, m_ready());
        for (int i = 0; i < NUM_SUBS; i++) begin
            ev = sub_en[i] && mq[i].size() > 0;
            chk($sformatf("rd_valid%0d", i), rd_valid[i], ev);
            chk($sformatf("level%0d", i), level[i*PW +: PW], mq[i].size());
            if (ev) chk($sformatf("rd_data%0d", i), rd_data[i*WIDTH +: WIDTH], mq[i][0]);
`ifdef DVV_BCAST_STAT_EN
            chk($sformatf("max_level%0d", i), max_level[i*PW +: PW], m_max[i]);
`endif
        end
`ifdef DVV_BCAST_STAT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        wr_valid = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        wr_valid = 1'b1;
        wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic async_reset();
        resetn = 1'b0;
        model_clear();
        #1;
        check_all();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        resetn   = 1'b0;
        flush    = 1'b0;
        sub_en   = '1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_rd_valid", rd_valid, 4'h0);
        resetn = 1'b1;
        tick();

        // 1: three writes, nobody pops
        wr(32'hA1);
        chk("t1_valid_after_first", rd_valid, 4'hF);
        wr(32'hA2);
        wr(32'hA3);
        for (int s = 0; s < NUM_SUBS; s++) begin
            chk("t1_level", level[s*PW +: PW], 3);
            chk("t1_data", rd_data[s*WIDTH +: WIDTH], 32'hA1);
        end

        // 2: subscriber 0 stalls while the others drain
        do_flush();
        rd_ready = 4'b1110;
        for (int k = 0; k < 8; k++) wr(32'h10 + k);
        chk("t2_full", wr_ready, 1'b0);
        chk("t2_level0", level[PW-1:0], 8);
        rd_ready = 4'b1111;
        wr(32'h99);
        chk("t2_refused_level0", level[PW-1:0], 7);
        chk("t2_ready_back", wr_ready, 1'b1);
        chk("t2_level1", level[PW +: PW], 0);
        rd_ready = '0;

        // 3: disable subscriber 2 mid-stream, re-enable, it sees only new data
        do_flush();
        for (int k = 0; k < 5; k++) wr(32'h20 + k);
        sub_en = 4'b1011;
        rd_ready = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            chk("t3_wr_ready", wr_ready, 1'b1);
            wr(32'h30 + k);
        end
        sub_en = 4'b1111;
        rd_ready = '0;
        wr(32'h55);
        chk("t3_level2", level[2*PW +: PW], 1);
        chk("t3_data2", rd_data[2*WIDTH +: WIDTH], 32'h55);

        // 4: streaming across pointer wrap
        do_flush();
        rd_ready = '1;
        for (int s = 0; s < NUM_SUBS; s++) got[s] = 0;
        for (int i = 0; i <= 40; i++) begin
            for (int s = 0; s < NUM_SUBS; s++)
                if (rd_valid[s]) begin
                    chk("t4_seq", rd_data[s*WIDTH +: WIDTH], (got[s] * 3) % 256);
                    got[s]++;
                end
            wr_valid = (i < 40);
            wr_data = (i * 3) % 256;
            tick();
        end
        wr_valid = 1'b0;
        for (int s = 0; s < NUM_SUBS; s++) begin
            chk("t4_count", got[s], 40);
            chk("t4_level", level[s*PW +: PW], 0);
        end

        // 5: flush beats a simultaneous write and pop
        do_flush();
        rd_ready = '0;
        for (int k = 0; k < 6; k++) wr(32'h60 + k);
        flush = 1'b1;
        wr_valid = 1'b1;
        wr_data = 32'hEE;
        rd_ready = '1;
        tick();
        flush = 1'b0;
        wr_valid = 1'b0;
        rd_ready = '0;
        chk("t5_level", level, '0);
        chk("t5_valid", rd_valid, 4'h0);
        tick();
        chk("t5_absent", rd_valid, 4'h0);

`ifdef DVV_BCAST_STAT_EN
        // 6: statistics
        do_flush();
        for (int k = 0; k < 8; k++) wr(32'h70 + k);
        wr_valid = 1'b1;
        repeat (5) tick();
        wr_valid = 1'b0;
        chk("t6_stall", stall_cnt, 5);
        chk("t6_max1", max_level[PW +: PW], 8);
        do_flush();
        chk("t6_stall_clr", stall_cnt, 0);
        chk("t6_max_clr", max_level, '0);
`endif

        // Randomized traffic with enable toggling, flushes and async resets
        do_flush();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(999) < 3) begin
                async_reset();
            end else begin
                flush    = ($urandom_range(79) == 0);
                wr_valid = ($urandom_range(3) != 0);
                wr_data  = $urandom;
                if (((n / 300) % 2) == 1) rd_ready = NUM_SUBS'($urandom & $urandom);
                else rd_ready = NUM_SUBS'($urandom);
                if ($urandom_range(39) == 0) sub_en[$urandom_range(NUM_SUBS-1)] ^= 1'b1;
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
